instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 117 +++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - LEGv8 instruction encoder with FIFO output buffer
module instr_encoder #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_class,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rn,
  input  logic [4:0]  in_rm,
  input  logic [18:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        illegal,
  input  logic        clr_illegal,
  output logic [15:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  localparam logic [2:0] CLS_LDUR = 3'b000;
  localparam logic [2:0] CLS_STUR = 3'b001;
  localparam logic [2:0] CLS_CBZ  = 3'b010;
  localparam logic [2:0] CLS_ADD  = 3'b011;
  localparam logic [2:0] CLS_SUB  = 3'b100;
  localparam logic [2:0] CLS_AND  = 3'b101;
  localparam logic [2:0] CLS_ORR  = 3'b110;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          in_ready_q, in_ready_d;
  logic          illegal_q, illegal_d;
  logic [15:0]   count_q, count_d;
  logic [31:0]   word;
  logic          accept, push, pop, is_illegal;

  // Encode the current request fields into a 32-bit LEGv8 word
  always_comb begin
    word = 32'h0;
    case (in_class)
      CLS_LDUR: word = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
      CLS_STUR: word = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
      CLS_CBZ:  word = {8'b10110100, in_imm, in_rd};
      CLS_ADD:  word = {11'b10001011000, in_rm, 6'b000000, in_rn, in_rd};
      CLS_SUB:  word = {11'b11001011000, in_rm, 6'b000000, in_rn, in_rd};
      CLS_AND:  word = {11'b10001010000, in_rm, 6'b000000, in_rn, in_rd};
      CLS_ORR:  word = {11'b10101010000, in_rm, 6'b000000, in_rn, in_rd};
      default:  word = 32'h0;
    endcase
  end

  // Handshakes, pointer/occupancy bookkeeping and sticky/counter next state
  always_comb begin
    is_illegal = (in_class == 3'b111);
    accept     = in_valid && in_ready_q;
    push       = accept && !is_illegal;
    pop        = (occ_q != '0) && out_ready;
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    occ_d      = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + OCC_ONE;
    end else if (pop && !push) begin
      occ_d = occ_q - OCC_ONE;
    end
    // in_ready is registered so that in_valid never reaches it combinationally
    in_ready_d = (occ_d != FULL_OCC);
    // A set on the same edge as a clear takes priority
    illegal_d  = (illegal_q && !clr_illegal) || (accept && is_illegal);
    count_d    = pop ? count_q + 16'd1 : count_q;
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      in_ready_q <= 1'b1;
      illegal_q  <= 1'b0;
      count_q    <= 16'h0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      in_ready_q <= in_ready_d;
      illegal_q  <= illegal_d;
      count_q    <= count_d;
    end
  end

  // Buffer storage; cleared on reset so out_instr reads zero afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (occ_q != '0);
  assign out_instr = mem_q[rd_ptr_q];
  assign illegal   = illegal_q;
  assign count     = count_q;

endmodule
